// File: rtl/servo_pkg.sv
// Shared FSM states, register map and pulse-width defaults for the servo slew sequencer.
package servo_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NUM_CH = 4;

  localparam int unsigned FRAME_CYCLES_DEF = 240000;
  localparam int unsigned PULSE_MIN_DEF    = 12000;
  localparam int unsigned PULSE_MAX_DEF    = 24000;
  localparam int unsigned PULSE_CENTER_DEF = 18000;
  localparam int unsigned DEFAULT_STEP_DEF = 120;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    COMPUTE = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_TARGET0 = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_TARGET1 = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_TARGET2 = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_TARGET3 = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_STEP    = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_ENABLE  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_DEBUG   = 3'd7;

  // Saturate a one-bit-wider value into the legal pulse window.
  function automatic logic [DATA_W-1:0] clamp_pulse(input logic [DATA_W:0]   v,
                                                     input logic [DATA_W-1:0] lo,
                                                     input logic [DATA_W-1:0] hi);
    logic [DATA_W-1:0] r;
    if (v < {1'b0, lo}) begin
      r = lo;
    end else if (v > {1'b0, hi}) begin
      r = hi;
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/servo_slew_sequencer_if.sv
// CPU-side register write/read port of the servo slew sequencer.
interface servo_slew_sequencer_if;
  import servo_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    output rd_data
  );

endinterface

// File: rtl/servo_slew_step.sv
// Combinational slew step: move cur toward tgt by at most step, then clamp to the pulse window.
module servo_slew_step
  import servo_pkg::*;
#(
  parameter int unsigned PULSE_MIN = PULSE_MIN_DEF,
  parameter int unsigned PULSE_MAX = PULSE_MAX_DEF
) (
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] tgt,
  input  logic [DATA_W-1:0] step,
  output logic [DATA_W-1:0] nxt,
  output logic              equal
);

  logic signed [DATA_W:0] diff;
  logic        [DATA_W:0] mag;
  logic        [DATA_W:0] raw;

  always_comb begin
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= {1'b0, step}) begin
      raw = {1'b0, tgt};
    end else if (!diff[DATA_W]) begin
      raw = {1'b0, cur} + {1'b0, step};
    end else begin
      raw = {1'b0, cur} - {1'b0, step};
    end
    nxt   = clamp_pulse(raw, DATA_W'(PULSE_MIN), DATA_W'(PULSE_MAX));
    equal = (nxt == tgt);
  end

endmodule

// File: rtl/servo_slew_sequencer.sv
// Four-channel servo position sequencer: slews PWM pulse widths toward CPU targets once per frame.
// Optional settle interrupt built when SERVO_SETTLE_IRQ_EN is defined.
module servo_slew_sequencer
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int unsigned PULSE_MIN    = PULSE_MIN_DEF,
  parameter int unsigned PULSE_MAX    = PULSE_MAX_DEF,
  parameter int unsigned PULSE_CENTER = PULSE_CENTER_DEF,
  parameter int unsigned DEFAULT_STEP = DEFAULT_STEP_DEF
) (
  input  logic                   raw_clk,
  input  logic                   reset_n,
  servo_slew_sequencer_if.slave  bus,
  output logic [DATA_W-1:0]      servo_value_0,
  output logic [DATA_W-1:0]      servo_value_1,
  output logic [DATA_W-1:0]      servo_value_2,
  output logic [DATA_W-1:0]      servo_value_3,
  output logic                   frame_start,
  output logic [NUM_CH-1:0]      settled,
  output logic                   settle_irq
);

  localparam int unsigned       CNT_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [DATA_W-1:0] CENTER   = DATA_W'(PULSE_CENTER);

  logic [CNT_W-1:0]  frame_cnt;
  logic [DATA_W-1:0] target_q  [NUM_CH];
  logic [DATA_W-1:0] current_q [NUM_CH];
  logic [DATA_W-1:0] servo_q   [NUM_CH];
  logic [DATA_W-1:0] step_q;
  logic [NUM_CH-1:0] enable_q;

  state_t            state;
  logic [1:0]        ch;
  logic [DATA_W-1:0] tgt_q;
  logic [DATA_W-1:0] cur_q;
  logic [DATA_W-1:0] nxt_q;
  logic              eq_q;
  logic [DATA_W-1:0] step_nxt;
  logic              step_eq;

  // Free-running frame counter; frame_start is high while the counter reads 0.
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else if (frame_cnt == CNT_LAST) begin
      frame_cnt   <= '0;
      frame_start <= 1'b1;
    end else begin
      frame_cnt   <= frame_cnt + CNT_W'(1);
      frame_start <= 1'b0;
    end
  end

  // CPU-writable registers; targets are saturated as they are written.
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) target_q[i] <= CENTER;
      step_q   <= DATA_W'(DEFAULT_STEP);
      enable_q <= '0;
    end else if (bus.wr_en) begin
      case (bus.wr_addr)
        ADDR_TARGET0, ADDR_TARGET1, ADDR_TARGET2, ADDR_TARGET3:
          target_q[bus.wr_addr[1:0]] <= clamp_pulse({1'b0, bus.wr_data},
                                                    DATA_W'(PULSE_MIN), DATA_W'(PULSE_MAX));
        ADDR_STEP:   step_q   <= bus.wr_data;
        ADDR_ENABLE: enable_q <= bus.wr_data[NUM_CH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rd_data <= '0;
    end else begin
      case (bus.rd_addr)
        ADDR_TARGET0, ADDR_TARGET1, ADDR_TARGET2, ADDR_TARGET3:
                     bus.rd_data <= target_q[bus.rd_addr[1:0]];
        ADDR_STEP:   bus.rd_data <= step_q;
        ADDR_ENABLE: bus.rd_data <= {{(DATA_W-NUM_CH){1'b0}}, enable_q};
        ADDR_STATUS: bus.rd_data <= {{(DATA_W-NUM_CH){1'b0}}, settled};
        ADDR_DEBUG:  bus.rd_data <= current_q[step_q[1:0]];
        default:     bus.rd_data <= '0;
      endcase
    end
  end

  servo_slew_step #(
    .PULSE_MIN (PULSE_MIN),
    .PULSE_MAX (PULSE_MAX)
  ) u_step (
    .cur   (cur_q),
    .tgt   (tgt_q),
    .step  (step_q),
    .nxt   (step_nxt),
    .equal (step_eq)
  );

  // Channel sweep: FETCH/COMPUTE/COMMIT per channel through the shared step unit.
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ch      <= 2'd0;
      tgt_q   <= CENTER;
      cur_q   <= CENTER;
      nxt_q   <= CENTER;
      eq_q    <= 1'b1;
      settled <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        current_q[i] <= CENTER;
        servo_q[i]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            ch    <= 2'd0;
            state <= FETCH;
          end
        end
        FETCH: begin
          tgt_q <= target_q[ch];
          cur_q <= current_q[ch];
          state <= COMPUTE;
        end
        COMPUTE: begin
          nxt_q <= step_nxt;
          eq_q  <= step_eq;
          state <= COMMIT;
        end
        COMMIT: begin
          current_q[ch] <= nxt_q;
          settled[ch]   <= eq_q;
          servo_q[ch]   <= enable_q[ch] ? nxt_q : '0;
          if (ch == 2'd3) begin
            state <= IDLE;
          end else begin
            ch    <= ch + 2'd1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign servo_value_0 = servo_q[0];
  assign servo_value_1 = servo_q[1];
  assign servo_value_2 = servo_q[2];
  assign servo_value_3 = servo_q[3];

`ifdef SERVO_SETTLE_IRQ_EN
  logic              all_ok_q;
  logic [NUM_CH-1:0] sweep_ok_c;

  // Channel 3's settle bit is still in flight during its COMMIT, so take it from eq_q.
  always_comb begin
    sweep_ok_c = {eq_q, settled[2:0]} | ~enable_q;
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      all_ok_q   <= 1'b1;
      settle_irq <= 1'b0;
    end else if ((state == COMMIT) && (ch == 2'd3)) begin
      settle_irq <= (&sweep_ok_c) & ~all_ok_q;
      all_ok_q   <= &sweep_ok_c;
    end else begin
      settle_irq <= 1'b0;
    end
  end
`else
  assign settle_irq = 1'b0;
`endif

endmodule

// File: tb/tb_servo_slew_sequencer.sv
// Directed self-checking bench for servo_slew_sequencer with a shortened frame.
module tb_servo_slew_sequencer;
  localparam int unsigned FRAME = 32;

  logic        raw_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sv0, sv1, sv2, sv3;
  logic        frame_start;
  logic [3:0]  settled;
  logic        settle_irq;
  int          total = 0;
  int          bad   = 0;
  int          irq_cnt = 0;

  servo_slew_sequencer_if bus();

  servo_slew_sequencer #(.FRAME_CYCLES(FRAME)) dut (
    .raw_clk       (raw_clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .servo_value_0 (sv0),
    .servo_value_1 (sv1),
    .servo_value_2 (sv2),
    .servo_value_3 (sv3),
    .frame_start   (frame_start),
    .settled       (settled),
    .settle_irq    (settle_irq)
  );

  always #5 raw_clk = ~raw_clk;

  always @(negedge raw_clk) if (settle_irq === 1'b1) irq_cnt++;

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge raw_clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge raw_clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge raw_clk);
    bus.rd_addr = a;
    @(negedge raw_clk);
    d = bus.rd_data;
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge raw_clk);
      n++;
    end while (frame_start !== 1'b1 && n < 3 * FRAME);
    if (frame_start !== 1'b1) begin
      total++; bad++;
      $display("FAIL frame_start_timeout waited=%0d cycles", n);
    end
  endtask

  task automatic sweep();
    wait_fs();
    repeat (13) @(negedge raw_clk);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    int n;
    repeat (3) @(negedge raw_clk);
    total++;
    if ({sv0, sv1, sv2, sv3} !== 64'h0) begin bad++; $display("FAIL rst_servo got=%h exp=0", {sv0, sv1, sv2, sv3}); end
    total++;
    if ({settled, frame_start, settle_irq} !== 6'b111100) begin
      bad++; $display("FAIL rst_flags got=%b exp=111100", {settled, frame_start, settle_irq});
    end
    total++;
    if (bus.rd_data !== 16'h0) begin bad++; $display("FAIL rst_rd_data got=%h exp=0", bus.rd_data); end
    @(negedge raw_clk) reset_n = 1'b1;
    n = 0;
    do begin @(negedge raw_clk); n++; end while (frame_start !== 1'b1 && n < 3 * FRAME);
    total++;
    if (n != FRAME) begin bad++; $display("FAIL rst_first_frame got=%0d exp=%0d", n, FRAME); end
    repeat (13) @(negedge raw_clk);
    rd(3'd0, d);
    total++;
    if (d !== 16'd18000) begin bad++; $display("FAIL rst_target0 got=%0d exp=18000", d); end
    rd(3'd6, d);
    total++;
    if (d !== 16'h000f) begin bad++; $display("FAIL rst_status got=%h exp=000f", d); end
    total++;
    if ({sv0, sv1, sv2, sv3, settle_irq} !== 65'h0) begin bad++; $display("FAIL rst_idle_out got=%h exp=0", {sv0, sv1, sv2, sv3, settle_irq}); end
  endtask

  task automatic test_ramp();
    logic [15:0] exp_v [5];
    logic [15:0] d;
    int irq_base, exp_irq;
    exp_v = '{16'd18120, 16'd18240, 16'd18360, 16'd18480, 16'd18500};
`ifdef SERVO_SETTLE_IRQ_EN
    exp_irq = 1;
`else
    exp_irq = 0;
`endif
    sweep();
    irq_base = irq_cnt;
    wr(3'd5, 16'h0001);
    wr(3'd0, 16'd18500);
    for (int i = 0; i < 5; i++) begin
      sweep();
      total++;
      if (sv0 !== exp_v[i]) begin bad++; $display("FAIL ramp_sv0[%0d] got=%0d exp=%0d", i, sv0, exp_v[i]); end
      rd(3'd6, d);
      total++;
      if (d !== ((i == 4) ? 16'h000f : 16'h000e)) begin bad++; $display("FAIL ramp_status[%0d] got=%h", i, d); end
    end
    total++;
    if (sv1 !== 16'd0) begin bad++; $display("FAIL ramp_sv1_disabled got=%0d exp=0", sv1); end
    sweep();
    sweep();
    total++;
    if (irq_cnt - irq_base != exp_irq) begin bad++; $display("FAIL ramp_irq got=%0d exp=%0d", irq_cnt - irq_base, exp_irq); end
  endtask

  task automatic test_clamp();
    logic [15:0] exp_dn [7];
    logic [15:0] d;
    exp_dn = '{16'd22000, 16'd20000, 16'd18000, 16'd16000, 16'd14000, 16'd12000, 16'd12000};
    wr(3'd1, 16'd30000);
    rd(3'd1, d);
    total++;
    if (d !== 16'd24000) begin bad++; $display("FAIL clamp_hi_readback got=%0d exp=24000", d); end
    wr(3'd4, 16'd2000);
    wr(3'd5, 16'h0002);
    sweep();
    total++;
    if (sv1 !== 16'd20000) begin bad++; $display("FAIL clamp_up1 got=%0d exp=20000", sv1); end
    total++;
    if (sv0 !== 16'd0) begin bad++; $display("FAIL clamp_sv0_off got=%0d exp=0", sv0); end
    sweep();
    sweep();
    total++;
    if (sv1 !== 16'd24000) begin bad++; $display("FAIL clamp_up3 got=%0d exp=24000", sv1); end
    sweep();
    total++;
    if (sv1 !== 16'd24000) begin bad++; $display("FAIL clamp_up_hold got=%0d exp=24000", sv1); end
    wr(3'd1, 16'd5000);
    rd(3'd1, d);
    total++;
    if (d !== 16'd12000) begin bad++; $display("FAIL clamp_lo_readback got=%0d exp=12000", d); end
    for (int i = 0; i < 7; i++) begin
      sweep();
      total++;
      if (sv1 !== exp_dn[i]) begin bad++; $display("FAIL clamp_dn[%0d] got=%0d exp=%0d", i, sv1, exp_dn[i]); end
    end
  endtask

  task automatic test_step_zero();
    logic [15:0] d;
    wr(3'd4, 16'd0);
    wr(3'd2, 16'd20000);
    wr(3'd5, 16'h0004);
    for (int i = 0; i < 3; i++) begin
      sweep();
      total++;
      if (sv2 !== 16'd18000) begin bad++; $display("FAIL step0_sv2[%0d] got=%0d exp=18000", i, sv2); end
    end
    rd(3'd6, d);
    total++;
    if (d !== 16'h000b) begin bad++; $display("FAIL step0_status got=%h exp=000b", d); end
    rd(3'd7, d);
    total++;
    if (d !== 16'd18500) begin bad++; $display("FAIL step0_debug_ch0 got=%0d exp=18500", d); end
    total++;
    if (sv1 !== 16'd0) begin bad++; $display("FAIL step0_sv1_off got=%0d exp=0", sv1); end
  endtask

  task automatic test_disable();
    logic [15:0] d;
    wr(3'd4, 16'd123);
    wr(3'd3, 16'd18246);
    wr(3'd5, 16'h000f);
    sweep();
    total++;
    if ({sv0, sv3} !== {16'd18500, 16'd18123}) begin bad++; $display("FAIL dis_en_all got=%0d/%0d exp=18500/18123", sv0, sv3); end
    wait_fs();
    wr(3'd5, 16'h0007);
    repeat (11) @(negedge raw_clk);
    total++;
    if (sv3 !== 16'd0) begin bad++; $display("FAIL dis_sv3_off got=%0d exp=0", sv3); end
    total++;
    if (sv2 !== 16'd18246) begin bad++; $display("FAIL dis_sv2 got=%0d exp=18246", sv2); end
    rd(3'd7, d);
    total++;
    if (d !== 16'd18246) begin bad++; $display("FAIL dis_debug_ch3 got=%0d exp=18246", d); end
    rd(3'd6, d);
    total++;
    if (d !== 16'h000b) begin bad++; $display("FAIL dis_status got=%h exp=000b", d); end
    wr(3'd3, 16'd18000);
    sweep();
    rd(3'd7, d);
    total++;
    if (d !== 16'd18123 || sv3 !== 16'd0) begin bad++; $display("FAIL dis_track got=%0d/%0d exp=18123/0", d, sv3); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    int n;
    wait_fs();
    repeat (5) @(negedge raw_clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({sv0, sv1, sv2, sv3} !== 64'h0) begin bad++; $display("FAIL mid_rst_servo got=%h exp=0", {sv0, sv1, sv2, sv3}); end
    total++;
    if ({settled, frame_start, settle_irq, bus.rd_data} !== {4'hf, 2'b00, 16'h0}) begin
      bad++; $display("FAIL mid_rst_flags got=%b/%h", {settled, frame_start, settle_irq}, bus.rd_data);
    end
    @(negedge raw_clk) reset_n = 1'b1;
    n = 0;
    do begin @(negedge raw_clk); n++; end while (frame_start !== 1'b1 && n < 3 * FRAME);
    total++;
    if (n != FRAME) begin bad++; $display("FAIL mid_rst_first_frame got=%0d exp=%0d", n, FRAME); end
    repeat (13) @(negedge raw_clk);
    rd(3'd3, d);
    total++;
    if (d !== 16'd18000) begin bad++; $display("FAIL mid_rst_target3 got=%0d exp=18000", d); end
    rd(3'd7, d);
    total++;
    if (d !== 16'd18000) begin bad++; $display("FAIL mid_rst_debug got=%0d exp=18000", d); end
    rd(3'd6, d);
    total++;
    if (d !== 16'h000f || sv0 !== 16'd0) begin bad++; $display("FAIL mid_rst_status got=%h/%0d exp=000f/0", d, sv0); end
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = 3'd0;
    bus.wr_data = 16'd0;
    bus.rd_addr = 3'd0;
    test_reset();
    test_ramp();
    test_clamp();
    test_step_zero();
    test_disable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servo_slew_sequencer.md
Name: servo_slew_sequencer

Overview:
- Per-channel position controller that sits between the CPU I/O channel write port and the 4-channel servo PWM generator.
- Holds CPU-written target pulse widths and, once per 20 ms frame, moves each channel's commanded pulse width toward its target by at most a programmable step.
- Uses one shared adder/comparator, sequenced across channels 0..3 by a small FSM.
- Drives the four 16-bit servo_value inputs of the PWM block.

Parameters:
- FRAME_CYCLES, 240000, clocks per update frame (20 ms at 12 MHz); must be >= 16.
- PULSE_MIN, 12000, lowest legal pulse width in clocks (1 ms).
- PULSE_MAX, 24000, highest legal pulse width in clocks (2 ms).
- PULSE_CENTER, 18000, reset value of targets and current positions.
- DEFAULT_STEP, 120, reset value of the step register, in clocks per frame.

Ports:
- raw_clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  register write strobe, one cycle.
- wr_addr  in  3  write register address.
- wr_data  in  16  write data.
- rd_addr  in  3  read register address.
- rd_data  out  16  read data, registered, 1-cycle latency.
- servo_value_0 .. servo_value_3  out  16 each  pulse width to the PWM block; 0 means no pulse.
- frame_start  out  1  one-cycle pulse at the start of each frame.
- settled  out  4  per channel: current position == target.
- settle_irq  out  1  see Optional Feature.

Behaviour:
- Reset (async assert, sync release): targets = PULSE_CENTER; current positions = PULSE_CENTER; step = DEFAULT_STEP; enable mask = 0; servo_value_* = 0; settled = 4'hf; rd_data = 0; frame_start = 0; settle_irq = 0; FSM in IDLE; frame counter = 0.
- Register map, write side:
  - Addresses 0-3: target for channels 0-3. The written value is clamped to [PULSE_MIN, PULSE_MAX] at write time.
  - Address 4: step. 16-bit; 0 freezes motion.
  - Address 5: enable mask, bits [3:0]; upper bits ignored.
  - Addresses 6-7: writes ignored.
- Register map, read side:
  - Addresses 0-3 return the clamped target.
  - Address 6 returns {12'b0, settled}.
  - Address 7 returns the current position of the channel selected by the step register's low 2 bits; this is a debug view.
- Frame counter:
  - Counts 0..FRAME_CYCLES-1 and wraps.
  - frame_start pulses in the cycle the counter equals 0.
  - The FSM leaves IDLE in the same cycle.
- FSM, cycle by cycle:
  - IDLE -> FETCH on frame_start, with ch = 0.
  - FETCH (1 cycle): latch tgt = target[ch] and cur = current[ch]. Any write landing in this same cycle is not seen until the next frame.
  - COMPUTE (1 cycle): diff = tgt - cur as a 17-bit signed value.
    - If |diff| <= step: nxt = tgt.
    - Else if diff > 0: nxt = cur + step.
    - Else: nxt = cur - step.
    - nxt is clamped to [PULSE_MIN, PULSE_MAX].
  - COMMIT (1 cycle): current[ch] = nxt. settled[ch] = (nxt == tgt). servo_value_ch = enable[ch] ? nxt : 0. If ch == 3, go to IDLE; else ch = ch+1 and go to FETCH.
  - One full sweep takes 12 cycles, so a sweep always finishes before the next frame_start.
- Disabled channel:
  - The slew still runs, so current position tracks the target.
  - The output is forced to 0 from that channel's next COMMIT.
  - Enable mask changes take effect at each channel's COMMIT, never mid-frame.
- Step = 0: current positions never change. settled reflects equality.
- Writes are accepted in every state; there is no busy or back-pressure.
- Reset asserted mid-sweep: everything returns to reset values immediately, and partially updated channels are discarded.
- The frame counter never stalls.

Optional Feature:
- Macro: SERVO_SETTLE_IRQ_EN.
- Defined: settle_irq pulses for 1 cycle, in the cycle after a COMMIT of ch 3, when (settled | ~enable) == 4'hf for that sweep and was not 4'hf after the previous sweep. This is a rising-edge detect across sweeps; its tracking register resets to 1.
- Undefined: settle_irq is tied to 0 and no tracking logic is built.

Decomposition:
- Shared package servo_pkg holds:
  - FSM state encodings (IDLE, FETCH, COMPUTE, COMMIT).
  - Register address constants (ADDR_TARGET0..3, ADDR_STEP, ADDR_ENABLE, ADDR_STATUS, ADDR_DEBUG).
  - PULSE_MIN/MAX/CENTER defaults.
- One sub-module, servo_slew_step: a combinational step/clamp unit taking cur, tgt, step and producing nxt and equal.

Test Plan:
- Reset, then read addr 0 and addr 6 -> rd_data 18000 and 0x000f; all servo_value_* = 0; settle_irq = 0.
- Write enable = 0x1, target0 = 18500, default step 120 -> servo_value_0 goes 18120, 18240, 18360, 18480, 18500 on successive frames; settled[0] = 1 after the 5th sweep; with SERVO_SETTLE_IRQ_EN, a single settle_irq pulse.
- Write target1 = 30000, enable = 0x2 -> target reads back 24000; output reaches 24000 and never exceeds it. Write target1 = 5000 -> output ramps down and stops at 12000.
- Write step = 0, then target2 = 20000 -> current position stays 18000 indefinitely; settled[2] = 0.
- Enable = 0xf, then clear bit 3 mid-frame -> servo_value_3 becomes 0 at that frame's (or the next frame's) ch 3 COMMIT. The debug read (step low bits = 3) shows the position still tracking the target.
- Assert reset_n low during COMPUTE of ch 1 -> all outputs return to reset values asynchronously; the first post-release frame_start comes FRAME_CYCLES after release.
